// File: rtl/tulip_dsp_pkg.sv
// Shared types and widths for the tulip DSP chain.
// Used by the coefficient programming path and its targets.
package tulip_dsp_pkg;

   localparam int C_ADC_DWIDTH           = 24;
   localparam int C_USER_FILT_TAP_DWIDTH = 16;

   typedef enum logic [1:0] {
      PS_OK         = 2'd0,
      PS_BAD_LEN    = 2'd1,
      PS_EARLY_DONE = 2'd2,
      PS_TIMEOUT    = 2'd3
   } prog_status_t;

endpackage

// File: rtl/tap_prog_streamer_if.sv
// Programming link between a streamer and a programmable DSP stage.
// The master streams words and owns the target's soft reset.
interface tap_prog_streamer_if #(
   parameter int G_DWIDTH = 24
);

   logic [G_DWIDTH-1:0] prog_dout;
   logic                prog_dout_valid;
   logic                prog_dout_ready;
   logic                prog_done;
   logic                target_resetn;

   modport master (
      output prog_dout,
      output prog_dout_valid,
      output target_resetn,
      input  prog_dout_ready,
      input  prog_done
   );

   modport slave (
      input  prog_dout,
      input  prog_dout_valid,
      input  target_resetn,
      output prog_dout_ready,
      output prog_done
   );

endinterface

// File: rtl/simple_dp_ram.sv
// One write port, one registered read port.
// Contents are not reset so a staged image survives soft resets.
module simple_dp_ram #(
   parameter int G_DWIDTH = 24,
   parameter int G_AWIDTH = 10
) (
   input  logic                clk,
   input  logic                we_i,
   input  logic [G_AWIDTH-1:0] waddr_i,
   input  logic [G_DWIDTH-1:0] wdata_i,
   input  logic                re_i,
   input  logic [G_AWIDTH-1:0] raddr_i,
   output logic [G_DWIDTH-1:0] rdata_o
);

   logic [G_DWIDTH-1:0] mem_q [2**G_AWIDTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/tap_prog_streamer.sv
// Stages a coefficient image, resets the target, streams the image
// into it and reports how the target's programming finished.
module tap_prog_streamer
   import tulip_dsp_pkg::*;
#(
   parameter int G_DWIDTH       = C_ADC_DWIDTH,
   parameter int G_DEPTH_LOG2   = 10,
   parameter int G_TRST_CYCLES  = 4,
   parameter int G_DONE_TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [G_DEPTH_LOG2-1:0] wr_addr,
   input  logic [G_DWIDTH-1:0]     wr_data,
   input  logic                    wr_en,
   input  logic [G_DEPTH_LOG2:0]   num_words,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              status,
   tap_prog_streamer_if.master     prog
);

   localparam int AW = G_DEPTH_LOG2;
   localparam int CW = AW + 1;
   localparam int RW = $clog2(G_TRST_CYCLES + 1);
   localparam int TW = $clog2(G_DONE_TIMEOUT + 1);

   localparam logic [CW-1:0] MAX_WORDS = {1'b1, {AW{1'b0}}};
   localparam logic [RW-1:0] TRST_LAST = RW'(G_TRST_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(G_DONE_TIMEOUT);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_TRST      = 3'd1;
   localparam logic [2:0] S_STREAM    = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_FINISH    = 3'd4;

   logic          rst;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] num_q, num_d;
   logic [CW-1:0] rcnt_q, rcnt_d;
   logic [CW-1:0] xcnt_q, xcnt_d;
   logic [RW-1:0] trst_q, trst_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0]    status_q, status_d;

   logic [G_DWIDTH-1:0] fifo_q [2];
   logic [G_DWIDTH-1:0] ram_rdata;
   logic                wptr_q, wptr_d;
   logic                rptr_q, rptr_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                rvld_q, rvld_d;

   logic       valid;
   logic       pop;
   logic       issue;
   logic       last_xfer;
   logic       flush;
   logic [2:0] occ;

   assign rst = reset | ~enable;

   simple_dp_ram #(
      .G_DWIDTH (G_DWIDTH),
      .G_AWIDTH (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en & (state_q == S_IDLE)),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .re_i    (issue),
      .raddr_i (rcnt_q[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   // Reads are issued only while FIFO plus in-flight read has room,
   // which keeps a 2-entry FIFO at one word per cycle.
   assign valid     = cnt_q != 2'd0;
   assign pop       = valid & prog.prog_dout_ready;
   assign occ       = {1'b0, cnt_q} + {2'b0, rvld_q} - {2'b0, pop};
   assign issue     = (state_q == S_STREAM) & (rcnt_q != num_q)
                    & (occ < 3'd2);
   assign last_xfer = pop & (xcnt_q == num_q - 1'b1);

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      trst_d   = trst_q;
      tmo_d    = tmo_q;
      status_d = status_q;
      rcnt_d   = rcnt_q + CW'(issue);
      xcnt_d   = xcnt_q + CW'(pop);
      flush    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            rcnt_d = '0;
            xcnt_d = '0;
            if (start) begin
               if (num_words == '0 || num_words > MAX_WORDS) begin
                  state_d  = S_FINISH;
                  status_d = PS_BAD_LEN;
               end else begin
                  num_d    = num_words;
                  status_d = PS_OK;
                  trst_d   = '0;
                  state_d  = S_TRST;
               end
            end
         end
         S_TRST: begin
            if (trst_q == TRST_LAST) state_d = S_STREAM;
            else trst_d = trst_q + 1'b1;
         end
         S_STREAM: begin
            if (prog.prog_done) begin
               state_d  = S_FINISH;
               status_d = PS_EARLY_DONE;
               flush    = 1'b1;
            end else if (last_xfer) begin
               state_d = S_WAIT_DONE;
               tmo_d   = '0;
            end
         end
         S_WAIT_DONE: begin
            if (prog.prog_done) begin
               state_d  = S_FINISH;
               status_d = PS_OK;
            end else if (tmo_q == TMO_LAST) begin
               state_d  = S_FINISH;
               status_d = PS_TIMEOUT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rvld_d = issue;
      wptr_d = wptr_q ^ rvld_q;
      rptr_d = rptr_q ^ pop;
      cnt_d  = cnt_q + {1'b0, rvld_q} - {1'b0, pop};
      if (flush) begin
         rvld_d = 1'b0;
         wptr_d = 1'b0;
         rptr_d = 1'b0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         num_q    <= '0;
         rcnt_q   <= '0;
         xcnt_q   <= '0;
         trst_q   <= '0;
         tmo_q    <= '0;
         status_q <= PS_OK;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         cnt_q    <= '0;
         rvld_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         rcnt_q   <= rcnt_d;
         xcnt_q   <= xcnt_d;
         trst_q   <= trst_d;
         tmo_q    <= tmo_d;
         status_q <= status_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         rvld_q   <= rvld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rvld_q) fifo_q[wptr_q] <= ram_rdata;
   end

   assign busy   = state_q != S_IDLE;
   assign done   = state_q == S_FINISH;
   assign status = status_q;

   assign prog.target_resetn   = state_q != S_TRST;
   assign prog.prog_dout_valid = valid;
   assign prog.prog_dout       = valid ? fifo_q[rptr_q] : '0;

endmodule

// File: tb/tb_tap_prog_streamer.sv
// Scoreboard bench for tap_prog_streamer: a staging-RAM model feeds
// expected words/status; a negedge monitor checks the DUT stream.
module tb_tap_prog_streamer;
   import tulip_dsp_pkg::*;

   localparam int DW    = 24;
   localparam int AL    = 10;
   localparam int TRST  = 4;
   localparam int TMO   = 1024;
   localparam int DEPTH = 1 << AL;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b1;
   logic [AL-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_en = 1'b0;
   logic [AL:0]   num_words = '0;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic [1:0]    status;

   tap_prog_streamer_if #(.G_DWIDTH(DW)) prog ();

   tap_prog_streamer #(
      .G_DWIDTH       (DW),
      .G_DEPTH_LOG2   (AL),
      .G_TRST_CYCLES  (TRST),
      .G_DONE_TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .num_words (num_words),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .status    (status),
      .prog      (prog.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs = 0;
   int errs = 0;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   prog_status_t  st_q [$];

   int c0 = 0;
   int trst_first, trst_cnt, first_valid, last_valid;
   int last_xfer, xfer_cnt, done_cnt, done_rel;
   bit prev_stall = 0;
   bit prev_done = 0;
   logic [DW-1:0] held;

   task automatic chk(input string name,
                      input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_status"}, status, 0);
      chk({tag, "_trstn"}, prog.target_resetn, 1);
      chk({tag, "_valid"}, prog.prog_dout_valid, 0);
      chk({tag, "_dout"}, prog.prog_dout, 0);
   endtask

   // Monitor: pops the scoreboard on every transfer and done pulse.
   always @(negedge clk) begin
      int rel;
      if (!reset && enable) begin
         rel = cyc - c0;
         if (!prog.target_resetn) begin
            trst_cnt++;
            if (trst_first < 0) trst_first = rel;
         end
         if (prev_done) chk("busy_after_done", busy, 0);
         prev_done = done;
         if (prog.prog_dout_valid) begin
            if (first_valid < 0) first_valid = rel;
            last_valid = rel;
            if (prev_stall) chk("stall_stable", prog.prog_dout, held);
         end
         prev_stall = prog.prog_dout_valid & ~prog.prog_dout_ready;
         held = prog.prog_dout;
         if (prog.prog_dout_valid && prog.prog_dout_ready) begin
            if (exp_q.size() == 0) begin
               vecs++;
               errs++;
               $display("FAIL extra_word: got %0h expected none",
                        prog.prog_dout);
            end else begin
               chk("word", prog.prog_dout, exp_q.pop_front());
            end
            xfer_cnt++;
            last_xfer = rel;
         end
         if (done) begin
            done_cnt++;
            done_rel = rel;
            if (st_q.size() == 0) begin
               vecs++;
               errs++;
               $display("FAIL unexpected_done: got status %0d", status);
            end else begin
               chk("status", status, st_q.pop_front());
            end
         end
      end else begin
         prev_stall = 0;
         prev_done = 0;
      end
   end

   task automatic write_word(input int a, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      wr_en = 1'b1;
      wr_addr = a[AL-1:0];
      wr_data = d;
      ref_mem[a] = d;
   endtask

   task automatic end_writes();
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   // dmode: 0 target done 2 cycles after last word, 1 never done,
   // 2 done forced after k words, 3 enable pulsed low after k words
   task automatic run_case(input int n, input int rmode,
                           input int dmode, input int k,
                           input bit junk);
      int u;
      int r;
      int bound;
      bit fired;
      bit bad;
      bad = (n == 0) || (n > DEPTH);
      if (!bad) begin
         for (int i = 0; i < ((dmode == 2) ? k : n); i++)
            exp_q.push_back(ref_mem[i]);
      end
      if (bad) st_q.push_back(PS_BAD_LEN);
      else if (dmode == 0) st_q.push_back(PS_OK);
      else if (dmode == 1) st_q.push_back(PS_TIMEOUT);
      else if (dmode == 2) st_q.push_back(PS_EARLY_DONE);
      trst_first = -1;
      trst_cnt = 0;
      first_valid = -1;
      last_valid = -1;
      last_xfer = -1;
      xfer_cnt = 0;
      done_cnt = 0;
      done_rel = -1;
      @(posedge clk);
      #1;
      start = 1'b1;
      num_words = (AL + 1)'(n);
      c0 = cyc;
      u = -1;
      fired = 0;
      bound = 4 * n + TMO + 200;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         r = cyc - c0;
         if (done_cnt > 0) break;
         case (rmode)
            0: prog.prog_dout_ready = 1'b1;
            1: prog.prog_dout_ready = (r % 2) == 0;
            default: prog.prog_dout_ready = 1'($urandom_range(0, 1));
         endcase
         prog.prog_done = 1'b0;
         if (junk) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = AL'($urandom);
            wr_data = DW'($urandom);
         end
         if (dmode == 0 && !fired && xfer_cnt == n
             && r == last_xfer + 2) begin
            prog.prog_done = 1'b1;
            fired = 1;
            u = r;
         end
         if (dmode == 2 && !fired && xfer_cnt == k) begin
            prog.prog_dout_ready = 1'b0;
            prog.prog_done = 1'b1;
            fired = 1;
            u = r;
         end
         if (dmode == 3 && !fired && xfer_cnt == k) begin
            prog.prog_dout_ready = 1'b0;
            enable = 1'b0;
            fired = 1;
            @(posedge clk);
            #1;
            enable = 1'b1;
            wr_en = 1'b0;
            @(negedge clk);
            chk_reset_vals("abort");
            exp_q.delete();
            break;
         end
      end
      wr_en = 1'b0;
      prog.prog_done = 1'b0;
      prog.prog_dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (dmode == 3) begin
         chk("abort_fired", fired, 1);
         chk("abort_words", xfer_cnt, k);
         chk("abort_no_done", done_cnt, 0);
      end else begin
         chk("done_count", done_cnt, 1);
         chk("leftover_words", exp_q.size(), 0);
         chk("leftover_status", st_q.size(), 0);
      end
      exp_q.delete();
      st_q.delete();
      if (bad) begin
         chk("bad_trst_cycles", trst_cnt, 0);
         chk("bad_no_valid", first_valid, -1);
         chk("bad_done_cycle", done_rel, 1);
         return;
      end
      chk("trst_first", trst_first, 1);
      chk("trst_cycles", trst_cnt, TRST);
      chk("first_valid", first_valid, TRST + 3);
      if (dmode == 0) begin
         chk("ok_done_cycle", done_rel, u + 1);
         if (rmode == 0) chk("burst_len", last_xfer - first_valid, n - 1);
      end
      if (dmode == 1) chk("tmo_done_cycle", done_rel, last_xfer + TMO + 2);
      if (dmode == 2) begin
         chk("early_valid_drop", last_valid, u);
         chk("early_words", xfer_cnt, k);
         chk("early_done_cycle", done_rel, u + 1);
      end
   endtask

   initial begin
      prog.prog_dout_ready = 1'b0;
      prog.prog_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("in_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("post_reset");

      for (int a = 0; a <= 128; a++) write_word(a, DW'(a * 3));
      end_writes();
      run_case(129, 0, 0, 0, 0);
      run_case(129, 1, 0, 0, 1);
      run_case(0, 0, 0, 0, 0);
      run_case(DEPTH + 1, 0, 0, 0, 0);
      run_case(5, 0, 1, 0, 0);
      run_case(129, 0, 2, 10, 0);
      run_case(129, 0, 3, 50, 1);
      run_case(129, 2, 0, 0, 0);

      for (int a = 0; a < DEPTH; a++) write_word(a, DW'($urandom));
      end_writes();
      run_case(DEPTH, 2, 0, 0, 1);
      for (int j = 0; j < 3; j++)
         run_case(int'($urandom_range(1, 300)), 2, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/tap_prog_streamer.md
# tap_prog_streamer

Initiator side of the coefficient/LUT programming handshake used by the DSP chain: the LUT transfer function, the user FIR and the reverb each expose a `*_prog_din` / `valid` / `ready` / `done` sink. The block stages a coefficient image written by the control plane, then on command resets the target and streams the image into it. It waits for the target's done flag and reports status. One instance sits between the register file and each programmable stage.

## Interface
Parameters:
- G_DWIDTH, 24 — programming word width (24 for LUT, 16 for FIR/reverb taps)
- G_DEPTH_LOG2, 10 — staging RAM depth = 2**G_DEPTH_LOG2 words
- G_TRST_CYCLES, 4 — cycles target_resetn held low before streaming
- G_DONE_TIMEOUT, 1024 — max cycles from last word to target done

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  active-high soft reset (global_sw_resetn); low behaves as reset
- wr_addr  in  G_DEPTH_LOG2  staging RAM write address
- wr_data  in  G_DWIDTH  staging RAM write data
- wr_en  in  1  staging write strobe
- num_words  in  G_DEPTH_LOG2+1  words to stream, sampled at start
- start  in  1  single-cycle launch request
- busy  out  1  high from start acceptance until done pulse
- done  out  1  one-cycle completion pulse (success or error)
- status  out  2  0 OK, 1 BAD_LEN, 2 EARLY_DONE, 3 TIMEOUT; held until next start
- target_resetn  out  1  to the target's sw_resetn
- prog_dout  out  G_DWIDTH  programming word
- prog_dout_valid  out  1  word valid
- prog_dout_ready  in  1  target ready
- prog_done  in  1  target programming complete

## Operation
- States: IDLE, TRST, STREAM, WAIT_DONE, FINISH.
- IDLE: wr_en writes the RAM. start with num_words==0 or >2**G_DEPTH_LOG2 → FINISH with BAD_LEN, and target_resetn is never lowered. Otherwise latch num_words, clear status → TRST.
- TRST: target_resetn=0 for G_TRST_CYCLES cycles → STREAM.
- STREAM: read addresses 0..num_words-1 in order through a 2-entry prefetch FIFO. prog_dout_valid = FIFO not empty. Word transfers on valid&ready. After the last transfer → WAIT_DONE. If prog_done is high during STREAM → FINISH with EARLY_DONE. Stop streaming; valid drops the next cycle.
- WAIT_DONE: timeout counter runs. prog_done=1 → FINISH OK. Counter reaches G_DONE_TIMEOUT → FINISH TIMEOUT.
- FINISH: done=1 for one cycle, busy=0 from the next cycle → IDLE.
- wr_en while busy is dropped and the RAM is unchanged. start while busy is ignored.
- prog_dout holds its value while valid&!ready (AXI-stream stability). Valid never retracts without a transfer, except on EARLY_DONE or reset.
- Reset/enable low at any point: immediate IDLE, FIFO flushed, counters cleared. RAM contents are kept.

## Timing
- Reset values: busy 0, done 0, status 0, target_resetn 1, prog_dout_valid 0, prog_dout 0.
- start sampled high at cycle 0 → busy=1 and target_resetn=0 at cycle 1 through cycle G_TRST_CYCLES. STREAM is entered at cycle G_TRST_CYCLES+1, with target_resetn=1.
- RAM read latency is 1 cycle. First prog_dout_valid comes 2 cycles after entering STREAM (cycle G_TRST_CYCLES+3).
- With ready held high: 1 word/cycle sustained, no bubbles.
- Last transfer at cycle t → WAIT_DONE at t+1. prog_done seen at cycle u → done=1 at u+1, busy=0 at u+2.
- BAD_LEN: done at cycle 1.
- Timeout: done 1 cycle after the counter hits G_DONE_TIMEOUT.

## Structure
- Shared package tulip_dsp_pkg: prog_status_t enum (OK, BAD_LEN, EARLY_DONE, TIMEOUT), plus C_ADC_DWIDTH=24 and C_USER_FILT_TAP_DWIDTH=16.
- Sub-module simple_dp_ram (1 write port, 1 registered read port, parameterised width/depth) holds the staging image.
- FSM, prefetch FIFO, word counter and timeout counter live in tap_prog_streamer.

## Test plan
- Write 0..128 with data=addr*3, num_words=129, ready=1, target asserts done 2 cycles after word 129 → target_resetn low cycles 1–4, words 0,3,…,384 back-to-back from cycle 7, status=0, done once.
- Same image, ready toggling 1/0 every cycle → identical word sequence, no duplicates/drops, prog_dout stable while stalled.
- num_words=0 and num_words=2**G_DEPTH_LOG2+1 → done at cycle 1, status=1, no valid, target_resetn stays 1.
- Target never asserts done, G_DONE_TIMEOUT=1024 → done 1025 cycles after WAIT_DONE entry, status=3.
- prog_done forced high after word 10 of 129 → status=2, valid drops the next cycle, no further words.
- enable low for 1 cycle mid-STREAM → outputs at reset values next cycle. A new start with unchanged RAM replays the full image from word 0. wr_en during busy leaves the RAM unchanged (verified on replay).
